// File: rtl/secded_pkg.sv
// Shared constants, codeword layout helpers and types for the (72,64) SECDED codec.
package secded_pkg;

    localparam int DATA_W = 64;
    localparam int CW_W   = 72;
    localparam int SYN_W  = 7;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_class_e;

    // Registered decoder result: corrected word plus error flags.
    typedef struct packed {
        logic [CW_W-1:0] data;
        logic            err;
        logic            s_err;
        logic            d_err;
    } dec_rsp_t;

    // Codeword position of data bit idx. Data fills every non-power-of-two
    // position in 1..71, in ascending order.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned p = 1; p < CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // XOR of the indices of all set bits at positions 1..71. On a data-only
    // word this is the check vector; on a received word it is the syndrome.
    function automatic logic [SYN_W-1:0] hamming_checks(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (cw[p]) s ^= p[SYN_W-1:0];
        end
        return s;
    endfunction

endpackage

// File: rtl/secded_parity_gen.sv
// Combinational check-vector / overall-parity generator shared by both paths.
module secded_parity_gen
    import secded_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [SYN_W-1:0] chk,
    output logic             par
);

    assign chk = hamming_checks(cw);
    assign par = ^cw;

endmodule

// File: rtl/secded_codec.sv
// (72,64) SECDED codec: independent registered encoder and decoder paths.
module secded_codec
    import secded_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] R_DATA,
    output logic [CW_W-1:0]   E_DATA,
    input  logic [CW_W-1:0]   N_DATA,
    output logic [CW_W-1:0]   D_DATA,
    output logic              ERR,
    output logic              D_ERR,
    output logic              S_ERR
);

    logic [CW_W-1:0]   enc_raw;
    logic [CW_W-1:0]   enc_cw;
    logic [SYN_W-1:0]  enc_chk;
    logic              enc_par;

    logic [SYN_W-1:0]  syn;
    logic              p_all;
    logic [CW_W-1:0]   flip;
    logic [CW_W-1:0]   dec_cw;
    logic [DATA_W-1:0] dec_data;
    err_class_e        cls;
    dec_rsp_t          dec_q;

    // Scatter data into its codeword positions and gather it back on decode.
    for (genvar i = 0; i < DATA_W; i++) begin : g_map
        localparam int unsigned POS = data_pos(i);
        assign enc_raw[POS] = R_DATA[i];
        assign dec_data[i]  = dec_cw[POS];
    end

    // Check and parity slots start empty so the generator sees data only.
    assign enc_raw[0] = 1'b0;
    for (genvar k = 0; k < SYN_W; k++) begin : g_chk_slot
        assign enc_raw[2**k] = 1'b0;
    end

    secded_parity_gen u_enc_pg (
        .cw  (enc_raw),
        .chk (enc_chk),
        .par (enc_par)
    );

    // Insert check bits; bit 0 covers data and check bits for even parity.
    always_comb begin
        enc_cw = enc_raw;
        for (int k = 0; k < SYN_W; k++) enc_cw[1 << k] = enc_chk[k];
        enc_cw[0] = enc_par ^ (^enc_chk);
    end

    // Encoder output register.
    always_ff @(posedge CLK) begin
        if (RST) E_DATA <= '0;
        else     E_DATA <= enc_cw;
    end

    secded_parity_gen u_dec_pg (
        .cw  (N_DATA),
        .chk (syn),
        .par (p_all)
    );

    // Classify the error and build the single-bit correction mask.
    // Odd parity with a syndrome past 71 points nowhere: odd multi-bit error.
    always_comb begin
        cls  = ERR_NONE;
        flip = '0;
        if (p_all) begin
            if (syn <= 7'd71) begin
                cls  = ERR_SINGLE;
                flip = CW_W'(1) << syn;
            end else begin
                cls = ERR_DOUBLE;
            end
        end else if (syn != '0) begin
            cls = ERR_DOUBLE;
        end
        dec_cw = N_DATA ^ flip;
    end

    // Decoder output register: word and flags update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dec_q <= '0;
        end else begin
            dec_q.data  <= {dec_cw[0], dec_cw[64], dec_cw[32], dec_cw[16],
                            dec_cw[8], dec_cw[4], dec_cw[2], dec_cw[1], dec_data};
            dec_q.err   <= (cls != ERR_NONE);
            dec_q.s_err <= (cls == ERR_SINGLE);
            dec_q.d_err <= (cls == ERR_DOUBLE);
        end
    end

    assign D_DATA = dec_q.data;
    assign ERR    = dec_q.err;
    assign S_ERR  = dec_q.s_err;
    assign D_ERR  = dec_q.d_err;

endmodule

// File: tb/tb_secded_codec.sv
// Directed and sweep bench for the SECDED codec, encoder looped into decoder.
module tb_secded_codec;

    logic        CLK;
    logic        RST;
    logic [63:0] R_DATA;
    logic [71:0] E_DATA;
    logic [71:0] N_DATA;
    logic [71:0] D_DATA;
    logic        ERR, D_ERR, S_ERR;

    logic        loop_en;
    logic [71:0] noise;
    logic [71:0] n_drv;

    int checks;
    int failures;

    assign N_DATA = loop_en ? (E_DATA ^ noise) : n_drv;

    secded_codec dut (
        .CLK    (CLK),
        .RST    (RST),
        .R_DATA (R_DATA),
        .E_DATA (E_DATA),
        .N_DATA (N_DATA),
        .D_DATA (D_DATA),
        .ERR    (ERR),
        .D_ERR  (D_ERR),
        .S_ERR  (S_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference encoder: data in non-power-of-two slots, each check bit is the
    // parity of the positions whose index has that bit set.
    function automatic logic [71:0] model_enc(input logic [63:0] d);
        logic [71:0] cw;
        logic        c;
        int          idx;
        cw  = '0;
        idx = 0;
        for (int p = 1; p < 72; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32 && p != 64) begin
                cw[p] = d[idx];
                idx++;
            end
        end
        for (int k = 0; k < 7; k++) begin
            c = 1'b0;
            for (int p = 1; p < 72; p++) if (((p >> k) & 1) == 1 && cw[p]) c = ~c;
            cw[1 << k] = c;
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    function automatic logic [7:0] model_chkbits(input logic [71:0] cw);
        return {cw[0], cw[64], cw[32], cw[16], cw[8], cw[4], cw[2], cw[1]};
    endfunction

    task automatic chk_flags(input string name, input logic e, input logic s, input logic d);
        // flags compared inline against the scenario's required class
        checks++;
        if ({ERR, S_ERR, D_ERR} !== {e, s, d}) begin
            failures++;
            $display("FAIL %s flags ERR/S/D got %b%b%b want %b%b%b", name, ERR, S_ERR, D_ERR, e, s, d);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; loop_en = 1'b0; noise = '0;
        R_DATA = 64'hDEAD_BEEF_CAFE_CAFE;
        n_drv  = 72'hFF_FFFF_FFFF_FFFF_FFFE;
        tick(); tick();
        checks++;
        if (E_DATA !== 72'h0) begin failures++; $display("FAIL reset_e got %h want 0", E_DATA); end
        checks++;
        if (D_DATA !== 72'h0) begin failures++; $display("FAIL reset_d got %h want 0", D_DATA); end
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        RST = 1'b0; R_DATA = '0; n_drv = '0;
        tick();
        checks++;
        if (D_DATA !== 72'h0) begin failures++; $display("FAIL zero_word_d got %h want 0", D_DATA); end
        checks++;
        if (E_DATA !== 72'h0) begin failures++; $display("FAIL zero_word_e got %h want 0", E_DATA); end
        chk_flags("zero_word", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_encode_directed();
        logic [63:0] din [3];
        logic [71:0] want [3];
        din[0] = 64'h1;                   want[0] = 72'h00_0000_0000_0000_000F;
        din[1] = 64'h2;                   want[1] = 72'h00_0000_0000_0000_0033;
        din[2] = 64'h8000_0000_0000_0000; want[2] = 72'h81_0000_0000_0000_0017;
        loop_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            R_DATA = din[i];
            tick();
            checks++;
            if (E_DATA !== want[i]) begin
                failures++;
                $display("FAIL enc_directed[%0d] got %h want %h", i, E_DATA, want[i]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [63:0] w [3];
        w[0] = 64'hDEAD_BEEF_CAFE_CAFE;
        w[1] = 64'hCAFE_CAFE_DEAD_BEEF;
        w[2] = 64'h1212_3434_5656_7878;
        loop_en = 1'b1; noise = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) R_DATA = w[i];
            tick();
            if (i < 3) begin
                checks++;
                if (E_DATA !== model_enc(w[i])) begin
                    failures++;
                    $display("FAIL rt_enc[%0d] got %h want %h", i, E_DATA, model_enc(w[i]));
                end
            end
            if (i >= 1) begin
                checks++;
                if (D_DATA !== {model_chkbits(model_enc(w[i-1])), w[i-1]}) begin
                    failures++;
                    $display("FAIL rt_dec[%0d] got %h want %h", i - 1, D_DATA,
                             {model_chkbits(model_enc(w[i-1])), w[i-1]});
                end
                chk_flags("rt", 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    // One word through encoder, channel noise and decoder.
    task automatic send(input logic [63:0] d, input logic [71:0] nz);
        loop_en = 1'b1; noise = nz; R_DATA = d;
        tick(); tick();
    endtask

    task automatic test_single_err();
        logic [63:0] d;
        d = 64'hDEAD_BEEF_CAFE_CAFE;
        send(d, 72'h00_0000_0000_0010_0000);
        checks++;
        if (D_DATA[63:0] !== d) begin failures++; $display("FAIL single_b20 got %h want %h", D_DATA[63:0], d); end
        chk_flags("single_b20", 1'b1, 1'b1, 1'b0);
        send(d, 72'h1);
        checks++;
        if (D_DATA !== {model_chkbits(model_enc(d)), d}) begin
            failures++;
            $display("FAIL single_b0 got %h want %h", D_DATA, {model_chkbits(model_enc(d)), d});
        end
        chk_flags("single_b0", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_double_err();
        logic [63:0] d, want;
        d    = 64'hDEAD_BEEF_CAFE_CAFE;
        want = d ^ (64'h1 << 45) ^ (64'h1 << 49);   // positions 52, 56
        send(d, 72'h00_0110_0000_0000_0000);
        checks++;
        if (D_DATA[63:0] !== want) begin failures++; $display("FAIL double got %h want %h", D_DATA[63:0], want); end
        chk_flags("double", 1'b1, 1'b0, 1'b1);
        // Three check-bit flips at 1, 8, 64: odd parity, syndrome 73 > 71
        send(d, 72'h01_0000_0000_0000_0102);
        checks++;
        if (D_DATA[63:0] !== d) begin failures++; $display("FAIL triple got %h want %h", D_DATA[63:0], d); end
        chk_flags("triple", 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_sweep();
        logic [63:0] d;
        for (int b = 0; b < 72; b++) begin
            d = {$urandom, $urandom};
            send(d, 72'h1 << b);
            checks++;
            if (D_DATA !== {model_chkbits(model_enc(d)), d}) begin
                failures++;
                $display("FAIL sweep bit %0d got %h want %h", b, D_DATA, {model_chkbits(model_enc(d)), d});
            end
            chk_flags("sweep", 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_pairs();
        logic [63:0] d;
        int a, b;
        for (int n = 0; n < 40; n++) begin
            d = {$urandom, $urandom};
            a = $urandom_range(71, 0);
            b = $urandom_range(70, 0);
            if (b >= a) b++;
            send(d, (72'h1 << a) | (72'h1 << b));
            chk_flags("pair", 1'b1, 1'b0, 1'b1);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        RST = 1'b1; R_DATA = '0; n_drv = '0; noise = '0; loop_en = 1'b0;
        test_reset();
        test_encode_directed();
        test_round_trip();
        test_single_err();
        test_double_err();
        test_sweep();
        test_pairs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
